mp3_ui_ctrl: RTL

- Front-panel controller between the raw push-buttons/player core and the mp3 display/audio path.
- Debounces the four buttons (next, previous, volume up, volume down) and emits single-cycle command pulses.
- Owns the track index, volume attenuation level, button-highlight hold timers and the cover-art reveal counter.
- The display consumes these as its i_next/i_pre/i_vol_*/vol_level/display_cnt sources, so the display no longer keeps timers of its own.

---
 rtl/mp3_ui_pkg.sv | 33 +++
 rtl/mp3_btn_debounce.sv | 92 +++++++++
 rtl/mp3_ui_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mp3_ui_pkg.sv
// Shared types and constants for the mp3 front-panel controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mp3_ui_pkg;

  localparam logic [3:0] VOL_MAX   = 4'd8;
  localparam logic [3:0] VOL_RESET = 4'd4;
  localparam int         REVEAL_W  = 12;
  localparam int         TRACK_W   = 4;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } db_state_e;

  // One track step forward or backward, wrapping inside 0..n_tracks-1.
  function automatic logic [TRACK_W-1:0] track_step(
    input logic [TRACK_W-1:0] trk,
    input logic               fwd,
    input int                 n_tracks
  );
    logic [TRACK_W-1:0] last;
    last = TRACK_W'(n_tracks - 1);
    if (fwd) begin
      track_step = (trk == last) ? '0 : trk + 1'b1;
    end else begin
      track_step = (trk == '0) ? last : trk - 1'b1;
    end
  endfunction

endpackage

// File: rtl/mp3_btn_debounce.sv
// Button synchronizer + debouncer; emits a one-cycle event on an accepted press.
// Latency: event registered 2 + DB_CYCLES cycles after a stable rising input.
// Backpressure: none, the event is a fire-and-forget pulse.
module mp3_btn_debounce
  import mp3_ui_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_event
);

  // The counter only needs to reach DB_CYCLES-1; the transition fires when it
  // is about to get there, so the compare value is DB_CYCLES-2.
  localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(DB_CYCLES - 2);

  logic             sync1_q, sync2_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             event_q, event_d;

  // Debounce FSM next-state: a level change must survive DB_CYCLES samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    event_d = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (sync2_q) begin
          state_d = CHK_HI;
          cnt_d   = '0;
        end
      end
      CHK_HI: begin
        if (!sync2_q) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_PRE_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = cnt_q + 1'b1;
          event_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!sync2_q) begin
          state_d = CHK_LO;
          cnt_d   = '0;
        end
      end
      CHK_LO: begin
        if (sync2_q) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_PRE_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // Synchronizer, FSM state and registered event pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      event_q <= 1'b0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      event_q <= event_d;
    end
  end

  assign o_event = event_q;

endmodule

// File: rtl/mp3_ui_ctrl.sv
// Front-panel controller: debounced buttons -> track/volume/highlight/reveal state.
// Latency: command pulses and state updates 1 cycle after the debounced event.
// Backpressure: none, all outputs are levels or one-cycle pulses.
module mp3_ui_ctrl
  import mp3_ui_pkg::*;
#(
  parameter int DB_CYCLES   = 1_000_000,
  parameter int HOLD_CYCLES = 50,
  parameter int REVEAL_DIV  = 3_000_000,
  parameter int REVEAL_MAX  = 2500,
  parameter int N_TRACKS    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_btn_next,
  input  logic                i_btn_pre,
  input  logic                i_btn_vup,
  input  logic                i_btn_vdn,
  input  logic                i_finish_song,
  output logic                o_next,
  output logic                o_pre,
  output logic                o_next_hl,
  output logic                o_pre_hl,
  output logic                o_vup_hl,
  output logic                o_vdn_hl,
  output logic [3:0]          o_vol_level,
  output logic [TRACK_W-1:0]  o_track,
  output logic [REVEAL_W-1:0] o_reveal_cnt,
  output logic                o_reveal_done
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int PRE_W  = (REVEAL_DIV > 1) ? $clog2(REVEAL_DIV) : 1;
  localparam logic [HOLD_W-1:0]   HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(REVEAL_DIV - 1);
  localparam logic [REVEAL_W-1:0] RVL_MAX   = REVEAL_W'(REVEAL_MAX);

  logic ev_next, ev_pre, ev_vup, ev_vdn;
  logic step_fwd, step_back, vol_up, vol_dn;

  logic                next_q, next_d, pre_q, pre_d;
  logic [HOLD_W-1:0]   nhold_q, nhold_d, phold_q, phold_d;
  logic [HOLD_W-1:0]   uhold_q, uhold_d, dhold_q, dhold_d;
  logic [3:0]          vol_q, vol_d;
  logic [TRACK_W-1:0]  track_q, track_d;
  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [REVEAL_W-1:0] rvl_q, rvl_d;
  logic                done_q, done_d;

  mp3_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_next (
    .clk(clk), .rst_n(rst_n), .i_btn(i_btn_next), .o_event(ev_next));
  mp3_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pre (
    .clk(clk), .rst_n(rst_n), .i_btn(i_btn_pre), .o_event(ev_pre));
  mp3_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_vup (
    .clk(clk), .rst_n(rst_n), .i_btn(i_btn_vup), .o_event(ev_vup));
  mp3_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_vdn (
    .clk(clk), .rst_n(rst_n), .i_btn(i_btn_vdn), .o_event(ev_vdn));

  // Arbitrate coincident events: next beats pre, a user command absorbs a
  // concurrent end-of-song, opposing volume presses cancel each other.
  always_comb begin
    step_fwd  = ev_next | (i_finish_song & ~ev_pre);
    step_back = ev_pre & ~ev_next;
    vol_up    = ev_vup & ~ev_vdn;
    vol_dn    = ev_vdn & ~ev_vup;
  end

  // Track index, command pulses and volume level.
  always_comb begin
    next_d  = step_fwd;
    pre_d   = step_back;
    track_d = track_q;
    if (step_fwd) begin
      track_d = track_step(track_q, 1'b1, N_TRACKS);
    end else if (step_back) begin
      track_d = track_step(track_q, 1'b0, N_TRACKS);
    end
    vol_d = vol_q;
    if (vol_up && vol_q != 4'd0) begin
      vol_d = vol_q - 1'b1;
    end else if (vol_dn && vol_q != VOL_MAX) begin
      vol_d = vol_q + 1'b1;
    end
  end

  // Highlight hold timers; next and pre highlights are mutually exclusive.
  // End-of-song steps the track but is not a button, so it leaves them alone.
  always_comb begin
    nhold_d = (nhold_q != '0) ? nhold_q - 1'b1 : nhold_q;
    phold_d = (phold_q != '0) ? phold_q - 1'b1 : phold_q;
    uhold_d = (uhold_q != '0) ? uhold_q - 1'b1 : uhold_q;
    dhold_d = (dhold_q != '0) ? dhold_q - 1'b1 : dhold_q;
    if (ev_next) begin
      nhold_d = HOLD_LOAD;
      phold_d = '0;
    end else if (step_back) begin
      phold_d = HOLD_LOAD;
      nhold_d = '0;
    end
    if (vol_up) uhold_d = HOLD_LOAD;
    if (vol_dn) dhold_d = HOLD_LOAD;
  end

  // Cover-art reveal: prescaled saturating counter, restarted on track change.
  always_comb begin
    presc_d = presc_q;
    rvl_d   = rvl_q;
    if (step_fwd || step_back) begin
      presc_d = '0;
      rvl_d   = '0;
    end else if (presc_q == PRE_LAST) begin
      presc_d = '0;
      if (rvl_q != RVL_MAX) rvl_d = rvl_q + 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
    done_d = (rvl_d == RVL_MAX);
  end

  // All controller state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_q  <= 1'b0;
      pre_q   <= 1'b0;
      nhold_q <= '0;
      phold_q <= '0;
      uhold_q <= '0;
      dhold_q <= '0;
      vol_q   <= VOL_RESET;
      track_q <= '0;
      presc_q <= '0;
      rvl_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      next_q  <= next_d;
      pre_q   <= pre_d;
      nhold_q <= nhold_d;
      phold_q <= phold_d;
      uhold_q <= uhold_d;
      dhold_q <= dhold_d;
      vol_q   <= vol_d;
      track_q <= track_d;
      presc_q <= presc_d;
      rvl_q   <= rvl_d;
      done_q  <= done_d;
    end
  end

  assign o_next        = next_q;
  assign o_pre         = pre_q;
  assign o_next_hl     = (nhold_q != '0);
  assign o_pre_hl      = (phold_q != '0);
  assign o_vup_hl      = (uhold_q != '0);
  assign o_vdn_hl      = (dhold_q != '0);
  assign o_vol_level   = vol_q;
  assign o_track       = track_q;
  assign o_reveal_cnt  = rvl_q;
  assign o_reveal_done = done_q;

endmodule
